block_mem_responder: RTL

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

---
 rtl/mem_pkg.sv | 11 +
 rtl/block_ram.sv | 38 +++
 rtl/block_mem_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the block memory responder.
package mem_pkg;
  localparam int BLOCK_W = 256;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } state_t;
endpackage

// File: rtl/block_ram.sv
// One-write / two-read synchronous block array; reads registered, write-first on same index.
// Latency 1 cycle; no backpressure, caller sequences we/re.
module block_ram
  import mem_pkg::*;
#(
  parameter  int N_BLOCKS = 64,
  localparam int IW       = $clog2(N_BLOCKS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [BLOCK_W-1:0] wdata,
  input  logic               re,
  input  logic [IW-1:0]      raddr_a,
  input  logic [IW-1:0]      raddr_b,
  output logic [BLOCK_W-1:0] rdata_a,
  output logic [BLOCK_W-1:0] rdata_b
);

  logic [BLOCK_W-1:0] mem [N_BLOCKS];

  // Array contents deliberately survive reset; only the read registers clear.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
      rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
    end
  end

endmodule

// File: rtl/block_mem_responder.sv
// Fixed-latency block memory: accepts a read and/or write in IDLE, waits LAT cycles, transfers.
// memready low for LAT+1 cycles per transaction; requests seen while busy are dropped.
module block_mem_responder
  import mem_pkg::*;
#(
  parameter int N_BLOCKS = 64,
  parameter int LAT      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               blockwrite,
  input  logic               blockread,
  input  logic [ADDR_W-1:0]  instraddr,
  input  logic [ADDR_W-1:0]  readaddr,
  input  logic [ADDR_W-1:0]  writeaddr,
  input  logic [BLOCK_W-1:0] writeblock,
  output logic [BLOCK_W-1:0] readblock,
  output logic [BLOCK_W-1:0] instrblock,
  output logic               memready
);

  localparam int IW = $clog2(N_BLOCKS);
  localparam int CW = $clog2(LAT + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               accept;
  logic               rd_q, wr_q;
  logic [IW-1:0]      ia_q, ra_q, wa_q;
  logic [BLOCK_W-1:0] wb_q;
  logic               ram_we, ram_re;

  // Address bits above the index alias onto the same block.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{instraddr[ADDR_W-1:IW], readaddr[ADDR_W-1:IW], writeaddr[ADDR_W-1:IW]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    memready  = 1'b0;
    case (state)
      IDLE: begin
        memready = 1'b1;
        if (blockread || blockwrite) begin
          accept    = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (cnt == CW'(LAT - 1)) begin
          state_nxt = XFER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      XFER:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else if (accept) begin
      rd_q <= blockread;
      wr_q <= blockwrite;
      ia_q <= instraddr[IW-1:0];
      ra_q <= readaddr[IW-1:0];
      wa_q <= writeaddr[IW-1:0];
      wb_q <= writeblock;
    end
  end

  // Reset during XFER must not commit the pending write.
  assign ram_we = (state == XFER) && wr_q && !reset;
  assign ram_re = (state == XFER) && rd_q;

  block_ram #(.N_BLOCKS(N_BLOCKS)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (ram_we),
    .waddr   (wa_q),
    .wdata   (wb_q),
    .re      (ram_re),
    .raddr_a (ra_q),
    .raddr_b (ia_q),
    .rdata_a (readblock),
    .rdata_b (instrblock)
  );

endmodule
